exception_sequencer: RTL and testbench

- Consumer end of the interrupt path: takes jisr/il/mca from the interrupt controller and carries out ISR entry and return.
- On entry it snapshots SR, cause and PCs into the exception SPRs, clears SR, and redirects fetch to the ISR base address.
- On eret it restores SR from ESR and redirects fetch to EPC.
- Owns the SR that feeds back into the interrupt controller. Sits between the interrupt controller, the SPR move path (movs2i/movi2s) and the fetch stage.

---
 rtl/exception_sequencer_pkg.sv | 39 +++
 rtl/exception_sequencer_if.sv | 22 ++
 rtl/exc_spr_file.sv | 67 ++++++
 rtl/exception_sequencer.sv | 111 +++++++++++
 tb/tb_exception_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/exception_sequencer_pkg.sv
// Shared types and constants for the exception sequencer.
// SPR map, FSM encoding, cause indices and the cause-to-EPC policy.
package exc_pkg;

  localparam logic [2:0] SPR_SR   = 3'd0;
  localparam logic [2:0] SPR_ESR  = 3'd1;
  localparam logic [2:0] SPR_ECA  = 3'd2;
  localparam logic [2:0] SPR_EPC  = 3'd3;
  localparam logic [2:0] SPR_EDPC = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAVE,
    ST_VECTOR,
    ST_RESTORE
  } state_t;

  localparam int CAUSE_RESET = 0;
  localparam int CAUSE_ILL   = 1;
  localparam int CAUSE_MAL   = 2;
  localparam int CAUSE_PFF   = 19;
  localparam int CAUSE_PFLS  = 20;

  localparam logic [22:0] REPEAT_MASK_DEF = 23'h1E0000;
  localparam logic [4:0]  IL_MAX = 5'd22;

  typedef struct packed {
    logic [4:0]  il;
    logic [22:0] mca;
    logic [31:0] pc;
    logic [31:0] pcn;
    logic [31:0] dpc;
  } hold_t;

  function automatic logic [4:0] clamp_il(input logic [4:0] il);
    return (il > IL_MAX) ? IL_MAX : il;
  endfunction

endpackage

// File: rtl/exception_sequencer_if.sv
// Fetch redirect handshake between the sequencer and the fetch stage.
// Payload (pc, flush) is held stable while valid waits for ready.
interface exception_sequencer_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        flush;

  modport master (
    output redirect_valid,
    output redirect_pc,
    output flush,
    input  redirect_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_pc,
    input  flush,
    output redirect_ready
  );
endinterface

// File: rtl/exc_spr_file.sv
// Exception SPRs with hardware-save priority over movi2s writes.
// Read port is combinational and shows stored contents only.
module exc_spr_file
  import exc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  wa,
  input  logic [31:0] wd,
  input  logic [2:0]  ra,
  output logic [31:0] rd,
  input  logic        save,
  input  hold_t       hold,
  input  logic        use_pc,
  input  logic        sr_clr,
  input  logic        sr_restore,
  output logic [31:0] sr,
  output logic [31:0] epc
);

  logic [31:0] esr;
  logic [31:0] eca;
  logic [31:0] edpc;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr   <= '0;
      esr  <= '0;
      eca  <= '0;
      epc  <= '0;
      edpc <= '0;
    end else if (save) begin
      esr  <= sr;
      eca  <= {9'd0, hold.mca};
      epc  <= use_pc ? hold.pc : hold.pcn;
      edpc <= hold.dpc;
      sr   <= '0;
    end else if (sr_clr) begin
      sr <= '0;
    end else if (sr_restore) begin
      sr <= esr;
    end else if (we) begin
      case (wa)
        SPR_SR:   sr   <= wd;
        SPR_ESR:  esr  <= wd;
        SPR_ECA:  eca  <= {9'd0, wd[22:0]};
        SPR_EPC:  epc  <= wd;
        SPR_EDPC: edpc <= wd;
        default:  ;
      endcase
    end
  end

  always_comb begin
    rd = '0;
    case (ra)
      SPR_SR:   rd = sr;
      SPR_ESR:  rd = esr;
      SPR_ECA:  rd = eca;
      SPR_EPC:  rd = epc;
      SPR_EDPC: rd = edpc;
      default:  rd = '0;
    endcase
  end

endmodule

// File: rtl/exception_sequencer.sv
// ISR entry/return sequencer: saves state, owns SR, redirects fetch.
// Requests arriving while busy are dropped; the source re-asserts.
module exception_sequencer
  import exc_pkg::*;
#(
  parameter logic [31:0] SISR        = 32'h0000_0000,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [22:0] REPEAT_MASK = REPEAT_MASK_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jisr,
  input  logic [4:0]  il,
  input  logic [22:0] mca,
  input  logic [31:0] pc,
  input  logic [31:0] pc_next,
  input  logic [31:0] dpc,
  input  logic        eret,
  input  logic        spr_we,
  input  logic [2:0]  spr_wa,
  input  logic [31:0] spr_wd,
  input  logic [2:0]  spr_ra,
  output logic [31:0] spr_rd,
  output logic [31:0] sr,
  exception_sequencer_if.master rdr,
  output logic        busy
);

  state_t      state;
  state_t      state_n;
  hold_t       hold;
  logic [31:0] tgt;
  logic [31:0] epc;
  logic        idle;
  logic        rst_req;
  logic        rv;
  logic [31:0] rpc;

  assign idle    = (state == ST_IDLE);
  assign rst_req = idle && jisr && (il == 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      hold  <= '0;
      tgt   <= '0;
    end else begin
      state <= state_n;
      if (idle && jisr) begin
        hold.il  <= clamp_il(il);
        hold.mca <= mca;
        hold.pc  <= pc;
        hold.pcn <= pc_next;
        hold.dpc <= dpc;
        tgt      <= (il == 5'd0) ? RESET_PC : SISR;
      end
    end
  end

  always_comb begin
    state_n = state;
    rv      = 1'b0;
    rpc     = '0;
    unique case (state)
      ST_IDLE: begin
        if (jisr)
          state_n = (il == 5'd0) ? ST_VECTOR : ST_SAVE;
        else if (eret)
          state_n = ST_RESTORE;
      end
      ST_SAVE: state_n = ST_VECTOR;
      ST_VECTOR: begin
        rv  = 1'b1;
        rpc = tgt;
        if (rdr.redirect_ready)
          state_n = ST_IDLE;
      end
      ST_RESTORE: begin
        rv  = 1'b1;
        rpc = epc;
        if (rdr.redirect_ready)
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign rdr.redirect_valid = rv;
  assign rdr.redirect_pc    = rpc;
  assign rdr.flush          = rv;
  assign busy               = !idle;

  // writes are dropped on any cycle where hardware also updates SPRs
  exc_spr_file u_spr (
    .clk        (clk),
    .reset      (reset),
    .we         (spr_we && idle && !jisr && !eret),
    .wa         (spr_wa),
    .wd         (spr_wd),
    .ra         (spr_ra),
    .rd         (spr_rd),
    .save       (state == ST_SAVE),
    .hold       (hold),
    .use_pc     (REPEAT_MASK[hold.il]),
    .sr_clr     (rst_req),
    .sr_restore (idle && eret && !jisr),
    .sr         (sr),
    .epc        (epc)
  );

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer.
// Inputs change 1ns after posedge; outputs are checked before the next edge.
module tb_exception_sequencer;
  import exc_pkg::*;

  localparam logic [31:0] T_SISR  = 32'h0000_1000;
  localparam logic [31:0] T_RSTPC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset;
  logic        jisr;
  logic [4:0]  il;
  logic [22:0] mca;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] dpc;
  logic        eret;
  logic        spr_we;
  logic [2:0]  spr_wa;
  logic [31:0] spr_wd;
  logic [2:0]  spr_ra;
  logic [31:0] spr_rd;
  logic [31:0] sr;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  exception_sequencer_if rif ();

  exception_sequencer #(
    .SISR     (T_SISR),
    .RESET_PC (T_RSTPC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .jisr    (jisr),
    .il      (il),
    .mca     (mca),
    .pc      (pc),
    .pc_next (pc_next),
    .dpc     (dpc),
    .eret    (eret),
    .spr_we  (spr_we),
    .spr_wa  (spr_wa),
    .spr_wd  (spr_wd),
    .spr_ra  (spr_ra),
    .spr_rd  (spr_rd),
    .sr      (sr),
    .rdr     (rif.master),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    spr_we = 1'b1;
    spr_wa = a;
    spr_wd = d;
    step();
    spr_we = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [2:0] a,
                       input logic [31:0] exp);
    spr_ra = a;
    #1;
    chk(tag, spr_rd, exp);
  endtask

  task automatic req(input logic [4:0] l, input logic [22:0] m,
                     input logic [31:0] p, input logic [31:0] pn,
                     input logic [31:0] dp);
    jisr    = 1'b1;
    il      = l;
    mca     = m;
    pc      = p;
    pc_next = pn;
    dpc     = dp;
  endtask

  task automatic accept();
    rif.redirect_ready = 1'b1;
    step();
    rif.redirect_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    jisr = 1'b0; il = '0; mca = '0;
    pc = '0; pc_next = '0; dpc = '0;
    eret = 1'b0; spr_we = 1'b0; spr_wa = '0;
    spr_wd = '0; spr_ra = '0;
    rif.redirect_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    chk("rst_sr", sr, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_valid", {31'd0, rif.redirect_valid}, 32'h0);
    chk("rst_pc", rif.redirect_pc, 32'h0);
    chk("rst_flush", {31'd0, rif.flush}, 32'h0);
    rdchk("rst_esr", SPR_ESR, 32'h0);
    rdchk("rst_epc", SPR_EPC, 32'h0);

    // interrupt entry, continue class
    wr(SPR_SR, 32'h0000_FFFF);
    chk("wr_sr", sr, 32'h0000_FFFF);
    req(5'd3, 23'h8, 32'h100, 32'h104, 32'h108);
    step();
    jisr = 1'b0;
    chk("save_busy", {31'd0, busy}, 32'h1);
    chk("save_valid", {31'd0, rif.redirect_valid}, 32'h0);
    step();
    chk("ent_valid", {31'd0, rif.redirect_valid}, 32'h1);
    chk("ent_pc", rif.redirect_pc, T_SISR);
    chk("ent_flush", {31'd0, rif.flush}, 32'h1);
    chk("ent_sr", sr, 32'h0);
    rdchk("ent_esr", SPR_ESR, 32'h0000_FFFF);
    rdchk("ent_eca", SPR_ECA, 32'h8);
    rdchk("ent_epc", SPR_EPC, 32'h104);
    rdchk("ent_edpc", SPR_EDPC, 32'h108);
    accept();
    chk("ent_idle", {31'd0, busy}, 32'h0);
    chk("ent_drop", {31'd0, rif.redirect_valid}, 32'h0);

    // repeat class, stalled handshake, busy write dropped
    req(5'd17, 23'h20000, 32'h200, 32'h204, 32'h208);
    step();
    jisr = 1'b0;
    step();
    rdchk("rep_epc", SPR_EPC, 32'h200);
    for (int i = 0; i < 3; i++) begin
      spr_we = 1'b1;
      spr_wa = SPR_EPC;
      spr_wd = 32'hDEAD;
      chk("stall_valid", {31'd0, rif.redirect_valid}, 32'h1);
      chk("stall_pc", rif.redirect_pc, T_SISR);
      chk("stall_busy", {31'd0, busy}, 32'h1);
      step();
    end
    spr_we = 1'b0;
    rdchk("busy_wr_epc", SPR_EPC, 32'h200);
    accept();
    chk("rep_idle", {31'd0, busy}, 32'h0);

    // eret
    wr(SPR_ESR, 32'h0000_FFFF);
    wr(SPR_EPC, 32'h104);
    eret = 1'b1;
    step();
    eret = 1'b0;
    chk("eret_sr", sr, 32'h0000_FFFF);
    chk("eret_valid", {31'd0, rif.redirect_valid}, 32'h1);
    chk("eret_pc", rif.redirect_pc, 32'h104);
    chk("eret_busy", {31'd0, busy}, 32'h1);
    accept();
    chk("eret_idle", {31'd0, busy}, 32'h0);

    // jisr and eret together
    wr(SPR_SR, 32'h1234);
    req(5'd5, 23'h20, 32'h300, 32'h304, 32'h308);
    eret = 1'b1;
    step();
    jisr = 1'b0;
    eret = 1'b0;
    chk("both_norest", {31'd0, rif.redirect_valid}, 32'h0);
    chk("both_sr0", sr, 32'h1234);
    step();
    chk("both_pc", rif.redirect_pc, T_SISR);
    chk("both_sr", sr, 32'h0);
    rdchk("both_esr", SPR_ESR, 32'h1234);
    rdchk("both_epc", SPR_EPC, 32'h304);
    accept();

    // write collision, il clamp 31->22 (continue)
    wr(SPR_SR, 32'h5555);
    req(5'd31, 23'h400000, 32'h600, 32'h604, 32'h608);
    spr_we = 1'b1;
    spr_wa = SPR_SR;
    spr_wd = 32'hAAAA;
    step();
    jisr = 1'b0;
    spr_we = 1'b0;
    chk("col_sr_keep", sr, 32'h5555);
    step();
    chk("col_sr", sr, 32'h0);
    rdchk("col_esr", SPR_ESR, 32'h5555);
    rdchk("clamp_epc", SPR_EPC, 32'h604);
    rdchk("col_eca", SPR_ECA, 32'h400000);
    wr(SPR_ESR, 32'h77);
    rdchk("busy_wr_esr", SPR_ESR, 32'h5555);
    accept();

    // reset during VECTOR
    req(5'd18, 23'h40000, 32'h700, 32'h704, 32'h708);
    step();
    jisr = 1'b0;
    step();
    chk("pre_rst_valid", {31'd0, rif.redirect_valid}, 32'h1);
    rdchk("pre_rst_epc", SPR_EPC, 32'h700);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("vrst_valid", {31'd0, rif.redirect_valid}, 32'h0);
    chk("vrst_busy", {31'd0, busy}, 32'h0);
    chk("vrst_sr", sr, 32'h0);
    rdchk("vrst_esr", SPR_ESR, 32'h0);
    rdchk("vrst_eca", SPR_ECA, 32'h0);
    rdchk("vrst_epc", SPR_EPC, 32'h0);
    rdchk("vrst_edpc", SPR_EDPC, 32'h0);

    // il == 0 reset vector, no save
    wr(SPR_ESR, 32'h42);
    wr(SPR_SR, 32'hF0);
    req(5'd0, 23'h1, 32'h800, 32'h804, 32'h808);
    step();
    jisr = 1'b0;
    chk("il0_valid", {31'd0, rif.redirect_valid}, 32'h1);
    chk("il0_pc", rif.redirect_pc, T_RSTPC);
    chk("il0_sr", sr, 32'h0);
    rdchk("il0_esr", SPR_ESR, 32'h42);
    rdchk("il0_eca", SPR_ECA, 32'h0);
    rdchk("il0_epc", SPR_EPC, 32'h0);
    rdchk("rd_hole", 3'd5, 32'h0);
    accept();
    chk("il0_idle", {31'd0, busy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
